// File: rtl/vec_debounce.sv
// Synchronise and debounce a WIDTH-bit raw vector as a whole. The vector is
// published with rise/fall/change strobes and a saturating accept counter.
module vec_debounce #(
  parameter int unsigned WIDTH         = 4,
  parameter int unsigned STABLE_CYCLES = 4
) (
  input  logic             clk,
  input  logic             areset,
  input  logic [WIDTH-1:0] raw,
  input  logic             clr_events,
  output logic [WIDTH-1:0] out,
  output logic             stable,
  output logic             changed,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall,
  output logic [7:0]       event_cnt
);

  localparam int unsigned        CNT_W    = 8;
  localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [7:0]         EVT_MAX  = 8'hFF;

  typedef enum logic [0:0] {
    ST_STABLE = 1'b0,
    ST_SETTLE = 1'b1
  } state_t;

  state_t           r_state, w_state_nxt;
  logic [WIDTH-1:0] r_sync1, r_sync2;
  logic [WIDTH-1:0] r_cand, w_cand_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic [WIDTH-1:0] r_out, w_out_nxt;
  logic             r_changed, w_changed_nxt;
  logic [WIDTH-1:0] r_rise, w_rise_nxt;
  logic [WIDTH-1:0] r_fall, w_fall_nxt;
  logic [7:0]       r_evt, w_evt_nxt;
  logic             w_accept;
  logic [WIDTH-1:0] w_s;

  assign w_s = r_sync2;

  // State and datapath registers; two-flop synchroniser on raw
  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      r_state   <= ST_STABLE;
      r_sync1   <= '0;
      r_sync2   <= '0;
      r_cand    <= '0;
      r_cnt     <= '0;
      r_out     <= '0;
      r_changed <= 1'b0;
      r_rise    <= '0;
      r_fall    <= '0;
      r_evt     <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_sync1   <= raw;
      r_sync2   <= r_sync1;
      r_cand    <= w_cand_nxt;
      r_cnt     <= w_cnt_nxt;
      r_out     <= w_out_nxt;
      r_changed <= w_changed_nxt;
      r_rise    <= w_rise_nxt;
      r_fall    <= w_fall_nxt;
      r_evt     <= w_evt_nxt;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    w_state_nxt   = r_state;
    w_cand_nxt    = r_cand;
    w_cnt_nxt     = r_cnt;
    w_out_nxt     = r_out;
    w_changed_nxt = 1'b0;
    w_rise_nxt    = '0;
    w_fall_nxt    = '0;
    w_evt_nxt     = r_evt;
    w_accept      = 1'b0;

    unique case (r_state)
      ST_STABLE: begin
        if (w_s != r_out) begin
          w_cand_nxt  = w_s;
          w_cnt_nxt   = CNT_W'(1);
          w_state_nxt = ST_SETTLE;
        end
      end
      ST_SETTLE: begin
        if (w_s == r_out) begin
          w_cnt_nxt   = '0;
          w_state_nxt = ST_STABLE;
        end else if (w_s != r_cand) begin
          w_cand_nxt = w_s;
          w_cnt_nxt  = CNT_W'(1);
        end else if (r_cnt >= CNT_LAST) begin
          w_accept    = 1'b1;
          w_cnt_nxt   = '0;
          w_state_nxt = ST_STABLE;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      default: w_state_nxt = ST_STABLE;
    endcase

    if (w_accept) begin
      w_out_nxt     = r_cand;
      w_changed_nxt = 1'b1;
      w_rise_nxt    = r_cand & ~r_out;
      w_fall_nxt    = ~r_cand & r_out;
      if (r_evt != EVT_MAX) w_evt_nxt = r_evt + 8'd1;
    end

    // Clear wins over a coincident increment
    if (clr_events) w_evt_nxt = '0;
  end

  assign out       = r_out;
  assign stable    = (r_state == ST_STABLE);
  assign changed   = r_changed;
  assign rise      = r_rise;
  assign fall      = r_fall;
  assign event_cnt = r_evt;

endmodule

// File: tb/tb_vec_debounce.sv
// Randomised and directed bench for vec_debounce against a run-length model.
module tb_vec_debounce;

  localparam int N = 4;

  logic       clk = 1'b0;
  logic       areset;
  logic [3:0] raw;
  logic       clr_events;
  logic [3:0] out;
  logic       stable;
  logic       changed;
  logic [3:0] rise;
  logic [3:0] fall;
  logic [7:0] event_cnt;

  int total = 0;
  int bad   = 0;

  vec_debounce #(.WIDTH(4), .STABLE_CYCLES(N)) dut (
    .clk(clk), .areset(areset), .raw(raw), .clr_events(clr_events),
    .out(out), .stable(stable), .changed(changed), .rise(rise),
    .fall(fall), .event_cnt(event_cnt)
  );

  always #5 clk = ~clk;

  // Model: out adopts a synchronised value once it has been seen N edges in a row
  logic [3:0] m_pipe[2];
  logic [3:0] m_last, m_out, m_rise, m_fall;
  int         m_run;
  logic       m_chg, m_stable;
  logic [7:0] m_evt;

  task automatic model_reset();
    m_pipe[0] = '0; m_pipe[1] = '0;
    m_last = '0; m_run = 0;
    m_out = '0; m_rise = '0; m_fall = '0;
    m_chg = 1'b0; m_stable = 1'b1; m_evt = '0;
  endtask

  // Drive one cycle of inputs, clock it, advance the model, settle past the edge
  task automatic drive(input logic [3:0] r, input logic c);
    logic [3:0] s;
    logic       acc;
    raw = r;
    clr_events = c;
    @(posedge clk);
    if (areset) begin
      model_reset();
    end else begin
      s = m_pipe[1];
      if (s == m_last) begin
        if (m_run < 1000) m_run++;
      end else begin
        m_last = s;
        m_run  = 1;
      end
      acc      = (s != m_out) && (m_run == N);
      m_stable = !((s != m_out) && !acc);
      m_chg    = acc;
      m_rise   = acc ? (s & ~m_out) : 4'b0;
      m_fall   = acc ? (~s & m_out) : 4'b0;
      if (acc) begin
        m_out = s;
        if (m_evt != 8'd255) m_evt = m_evt + 8'd1;
      end
      if (c) m_evt = 8'd0;
      m_pipe[1] = m_pipe[0];
      m_pipe[0] = r;
    end
    #1;
  endtask

  task automatic test_reset();
    raw = '0; clr_events = 1'b0; areset = 1'b1;
    model_reset();
    #12;
    total++;
    if ({out, stable, changed, rise, fall, event_cnt} !== {4'b0, 1'b1, 1'b0, 4'b0, 4'b0, 8'd0}) begin
      bad++;
      $display("FAIL reset_state: got out=%b st=%b chg=%b r=%b f=%b ev=%0d", out, stable, changed, rise, fall, event_cnt);
    end
    @(posedge clk); #1; areset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      drive(4'b0000, 1'b0);
      total++;
      if ({out, stable, changed, event_cnt} !== {4'b0, 1'b1, 1'b0, 8'd0}) begin
        bad++;
        $display("FAIL idle_zero[%0d]: got out=%b st=%b chg=%b ev=%0d exp 0000/1/0/0", i, out, stable, changed, event_cnt);
      end
    end
  endtask

  task automatic test_single_change();
    for (int i = 0; i < 9; i++) begin
      drive(4'b0101, 1'b0);
      total++;
      if ({out, changed, rise, fall} !== {(i >= 5) ? 4'b0101 : 4'b0000, i == 5,
                                          (i == 5) ? 4'b0101 : 4'b0000, 4'b0000}) begin
        bad++;
        $display("FAIL single_change[%0d]: got out=%b chg=%b r=%b f=%b", i, out, changed, rise, fall);
      end
    end
    total++;
    if (event_cnt !== 8'd1) begin
      bad++;
      $display("FAIL single_change_evt: got %0d exp 1", event_cnt);
    end
  endtask

  task automatic test_glitch();
    for (int i = 0; i < 10; i++) begin
      drive((i < 2) ? 4'b0111 : 4'b0101, 1'b0);
      total++;
      if ({out, changed, rise, fall, event_cnt} !== {4'b0101, 1'b0, 4'b0, 4'b0, 8'd1} ||
          stable !== m_stable) begin
        bad++;
        $display("FAIL glitch[%0d]: got out=%b chg=%b ev=%0d st=%b exp 0101/0/1 st=%b", i, out, changed, event_cnt, stable, m_stable);
      end
    end
    total++;
    if (stable !== 1'b1) begin
      bad++;
      $display("FAIL glitch_stable: got %b exp 1", stable);
    end
  endtask

  task automatic test_restart();
    for (int i = 0; i < 12; i++) begin
      drive((i < 2) ? 4'b0011 : 4'b1010, 1'b0);
      total++;
      if ({out, changed, rise, fall} !== {(i >= 7) ? 4'b1010 : 4'b0101, i == 7,
                                          (i == 7) ? 4'b1010 : 4'b0000,
                                          (i == 7) ? 4'b0101 : 4'b0000}) begin
        bad++;
        $display("FAIL restart[%0d]: got out=%b chg=%b r=%b f=%b", i, out, changed, rise, fall);
      end
    end
  endtask

  task automatic test_random();
    logic [3:0] r;
    int         hold;
    int         cyc = 0;
    while (cyc < 400) begin
      r    = 4'($urandom);
      hold = $urandom_range(1, 7);
      for (int h = 0; h < hold; h++) begin
        drive(r, ($urandom_range(0, 15) == 0));
        cyc++;
        total++;
        if ({out, stable, changed, rise, fall, event_cnt} !== {m_out, m_stable, m_chg, m_rise, m_fall, m_evt}) begin
          bad++;
          $display("FAIL random[%0d]: got out=%b st=%b chg=%b r=%b f=%b ev=%0d exp out=%b st=%b chg=%b r=%b f=%b ev=%0d",
                   cyc, out, stable, changed, rise, fall, event_cnt, m_out, m_stable, m_chg, m_rise, m_fall, m_evt);
        end
      end
    end
  endtask

  task automatic test_saturation();
    int pulses = 0;
    areset = 1'b1; model_reset(); #2;
    @(posedge clk); #1; areset = 1'b0;
    for (int k = 0; k < 300; k++) begin
      for (int t = 0; t < 8; t++) begin
        drive((k % 2 == 0) ? 4'b1111 : 4'b0000, (k == 10) && (t == 5));
        if (changed === 1'b1) pulses++;
        total++;
        if ({out, stable, changed, rise, fall, event_cnt} !== {m_out, m_stable, m_chg, m_rise, m_fall, m_evt}) begin
          bad++;
          $display("FAIL saturate[%0d.%0d]: got out=%b chg=%b ev=%0d exp out=%b chg=%b ev=%0d",
                   k, t, out, changed, event_cnt, m_out, m_chg, m_evt);
        end
        if (k == 10 && t == 5) begin
          total++;
          if ({changed, event_cnt} !== {1'b1, 8'd0}) begin
            bad++;
            $display("FAIL clr_on_accept: got chg=%b ev=%0d exp 1/0", changed, event_cnt);
          end
        end
      end
    end
    total++;
    if (event_cnt !== 8'd255 || pulses != 300) begin
      bad++;
      $display("FAIL saturate_end: got ev=%0d pulses=%0d exp 255/300", event_cnt, pulses);
    end
  endtask

  task automatic test_reset_mid_settle();
    for (int i = 0; i < 8; i++) drive(4'b0011, 1'b0);
    total++;
    if (out !== 4'b0011) begin
      bad++;
      $display("FAIL pre_settle: got out=%b exp 0011", out);
    end
    for (int i = 0; i < 4; i++) drive(4'b1100, 1'b0);
    total++;
    if ({out, stable} !== {4'b0011, 1'b0}) begin
      bad++;
      $display("FAIL mid_settle: got out=%b st=%b exp 0011/0", out, stable);
    end
    areset = 1'b1;
    model_reset();
    #1;
    total++;
    if ({out, stable, changed, rise, fall, event_cnt} !== {4'b0, 1'b1, 1'b0, 4'b0, 4'b0, 8'd0}) begin
      bad++;
      $display("FAIL async_reset: got out=%b st=%b chg=%b ev=%0d exp 0000/1/0/0", out, stable, changed, event_cnt);
    end
    for (int i = 0; i < 3; i++) begin
      drive(4'b1100, 1'b0);
      total++;
      if ({out, changed, rise, fall} !== {4'b0, 1'b0, 4'b0, 4'b0}) begin
        bad++;
        $display("FAIL in_reset[%0d]: got out=%b chg=%b r=%b f=%b exp all 0", i, out, changed, rise, fall);
      end
    end
    areset = 1'b0;
    for (int i = 0; i < 9; i++) begin
      drive(4'b1100, 1'b0);
      total++;
      if ({out, changed, rise} !== {(i >= 5) ? 4'b1100 : 4'b0000, i == 5,
                                    (i == 5) ? 4'b1100 : 4'b0000}) begin
        bad++;
        $display("FAIL reacquire[%0d]: got out=%b chg=%b r=%b", i, out, changed, rise);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_change();
    test_glitch();
    test_restart();
    test_random();
    test_saturation();
    test_reset_mid_settle();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
